// File: rtl/vga_timing_gen_param_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package  : vga_timing_pkg                                                  |
// | Purpose  : Shared constants for the parametrised VGA timing generator:     |
// |            default 640x480@60 raster geometry, sync polarity encodings,    |
// |            and helpers for deriving raster totals.                         |
// | Ports    : none (package)                                                  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package vga_timing_pkg;

  // Default 640x480@60 geometry (pixels / lines).
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam int DEF_CLK_DIV  = 4;
  localparam int DEF_CW       = 10;

  // Sync polarity encodings: the value is the level driven while sync is active.
  localparam bit POL_ACTIVE_LOW  = 1'b0;
  localparam bit POL_ACTIVE_HIGH = 1'b1;

  // Total length of one dimension of the raster.
  function automatic int total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage : vga_timing_pkg
`default_nettype wire

// File: rtl/vga_timing_gen_param_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface: vga_timing_gen_param_if                                         |
// | Purpose  : Raster timing bundle from the timing generator to the pixel /   |
// |            colour generator. All signals are in the system clock domain.   |
// | Signals  : pixel_tick  - one-clk pixel enable                              |
// |            h_sync      - horizontal sync (polarity set by generator)       |
// |            v_sync      - vertical sync (polarity set by generator)         |
// |            video_on    - high inside the visible area                      |
// |            pixel_x/y   - current column / row                              |
// |            line_start  - one-clk pulse when pixel_x wraps to 0             |
// |            frame_start - one-clk pulse when (x,y) wraps to (0,0)           |
// | Modports : master (timing generator), slave (pixel consumer)               |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
interface vga_timing_gen_param_if #(
  parameter int CW = 10
);
  logic          pixel_tick;
  logic          h_sync;
  logic          v_sync;
  logic          video_on;
  logic [CW-1:0] pixel_x;
  logic [CW-1:0] pixel_y;
  logic          line_start;
  logic          frame_start;

  modport master (
    output pixel_tick, h_sync, v_sync, video_on,
    output pixel_x, pixel_y, line_start, frame_start
  );

  modport slave (
    input pixel_tick, h_sync, v_sync, video_on,
    input pixel_x, pixel_y, line_start, frame_start
  );
endinterface : vga_timing_gen_param_if
`default_nettype wire

// File: rtl/vga_timing_gen_param_pixel_div.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : vga_pixel_div                                                   |
// | Purpose  : Divides the system clock into a one-clk pixel-rate enable.      |
// |            The divider free-runs 0..CLK_DIV-1 while enabled and holds      |
// |            its position while disabled.                                    |
// | Ports    : clk          in  system clock                                   |
// |            reset        in  asynchronous active-low reset                  |
// |            enable_i     in  run enable                                     |
// |            pixel_tick_o out high on the clk where the divider is at its    |
// |                             last count (constantly = enable for div 1)     |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module vga_pixel_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic enable_i,
  output logic pixel_tick_o
);

  // A 1-bit counter is kept even for CLK_DIV=1; it simply never leaves 0.
  localparam int            DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_q;
  logic [DW-1:0] div_d;

  always_comb begin
    div_d = div_q;
    if (enable_i) begin
      div_d = (div_q == DIV_LAST) ? '0 : div_q + DW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

  // The tick is combinational so that dropping enable silences it at once.
  // Gating with reset keeps it low during reset when CLK_DIV=1.
  assign pixel_tick_o = reset & enable_i & (div_q == DIV_LAST);

endmodule : vga_pixel_div
`default_nettype wire

// File: rtl/vga_timing_gen_param.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : vga_timing_gen_param                                            |
// | Purpose  : Parametrised VGA raster timing generator. Runs horizontal and   |
// |            vertical counters on a divided pixel enable and produces sync,  |
// |            blanking, coordinates and line/frame pulses, all registered     |
// |            one clk behind the counters so they stay mutually aligned.      |
// | Ports    : clk     in  system clock                                        |
// |            reset   in  asynchronous active-low reset                       |
// |            enable  in  run enable; low freezes all timing                  |
// |            vga_o   master modport of vga_timing_gen_param_if carrying      |
// |                    pixel_tick, h_sync, v_sync, video_on, pixel_x,          |
// |                    pixel_y, line_start, frame_start                        |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module vga_timing_gen_param
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit HS_POL   = POL_ACTIVE_LOW,
  parameter bit VS_POL   = POL_ACTIVE_LOW,
  parameter int CLK_DIV  = DEF_CLK_DIV,
  parameter int CW       = DEF_CW
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  vga_timing_gen_param_if.master vga_o
);

  localparam int H_TOTAL   = total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL   = total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int MAX_TOTAL = max2(H_TOTAL, V_TOTAL);

  localparam logic [CW-1:0] H_LAST     = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST     = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_VIS      = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_VIS      = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_FIRST   = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_LAST    = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CW-1:0] VS_FIRST   = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_LAST    = CW'(V_ACTIVE + V_FP + V_SYNC - 1);

  // Reject geometries whose totals cannot be represented in CW bits, and
  // dividers that would never produce a tick.
  generate
    if (((64'd1 << CW) < 64'(MAX_TOTAL)) || (CLK_DIV < 1)) begin : g_param_check
      $error("vga_timing_gen_param: CW too small for raster totals or CLK_DIV < 1");
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Pixel-rate enable
  // --------------------------------------------------------------------------
  logic pixel_tick;

  vga_pixel_div #(
    .CLK_DIV (CLK_DIV)
  ) u_pixel_div (
    .clk          (clk),
    .reset        (reset),
    .enable_i     (enable),
    .pixel_tick_o (pixel_tick)
  );

  // --------------------------------------------------------------------------
  // Raster counters
  // --------------------------------------------------------------------------
  logic [CW-1:0] h_cnt_q, h_cnt_d;
  logic [CW-1:0] v_cnt_q, v_cnt_d;

  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (pixel_tick) begin
      if (h_cnt_q == H_LAST) begin
        h_cnt_d = '0;
        v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + CW'(1);
      end else begin
        h_cnt_d = h_cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  // --------------------------------------------------------------------------
  // Decode and output registers
  // --------------------------------------------------------------------------
  logic hs_active;
  logic vs_active;
  logic in_visible;

  assign hs_active  = (h_cnt_q >= HS_FIRST) && (h_cnt_q <= HS_LAST);
  assign vs_active  = (v_cnt_q >= VS_FIRST) && (v_cnt_q <= VS_LAST);
  assign in_visible = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);

  logic          h_sync_q,      h_sync_d;
  logic          v_sync_q,      v_sync_d;
  logic          video_on_q,    video_on_d;
  logic [CW-1:0] pixel_x_q,     pixel_x_d;
  logic [CW-1:0] pixel_y_q,     pixel_y_d;
  logic          line_start_q,  line_start_d;
  logic          frame_start_q, frame_start_d;

  always_comb begin
    h_sync_d      = h_sync_q;
    v_sync_d      = v_sync_q;
    video_on_d    = video_on_q;
    pixel_x_d     = pixel_x_q;
    pixel_y_d     = pixel_y_q;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    if (enable) begin
      h_sync_d   = hs_active ? HS_POL : ~HS_POL;
      v_sync_d   = vs_active ? VS_POL : ~VS_POL;
      video_on_d = in_visible;
      pixel_x_d  = h_cnt_q;
      pixel_y_d  = v_cnt_q;
      // Pulses are derived from the registered coordinate actually wrapping,
      // so the implicit (0,0) after reset never produces one.
      line_start_d  = (h_cnt_q == '0) && (pixel_x_q == H_LAST);
      frame_start_d = line_start_d && (v_cnt_q == '0) && (pixel_y_q == V_LAST);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      h_sync_q      <= ~HS_POL;
      v_sync_q      <= ~VS_POL;
      video_on_q    <= 1'b0;
      pixel_x_q     <= '0;
      pixel_y_q     <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      h_sync_q      <= h_sync_d;
      v_sync_q      <= v_sync_d;
      video_on_q    <= video_on_d;
      pixel_x_q     <= pixel_x_d;
      pixel_y_q     <= pixel_y_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign vga_o.pixel_tick  = pixel_tick;
  assign vga_o.h_sync      = h_sync_q;
  assign vga_o.v_sync      = v_sync_q;
  assign vga_o.video_on    = video_on_q;
  assign vga_o.pixel_x     = pixel_x_q;
  assign vga_o.pixel_y     = pixel_y_q;
  assign vga_o.line_start  = line_start_q;
  assign vga_o.frame_start = frame_start_q;

endmodule : vga_timing_gen_param
`default_nettype wire

// File: tb/tb_vga_timing_gen_param.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module   : tb_vga_timing_gen_param                                         |
// | Purpose  : Self-checking bench for vga_timing_gen_param. Three instances:  |
// |            dut_def   - default 640x480, CLK_DIV=4                          |
// |            dut_small - 8x6 raster, active-high syncs, CLK_DIV=1            |
// |            dut_tall  - 4-pixel lines, default vertical timing, CLK_DIV=1   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_vga_timing_gen_param;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic en_def = 1'b0;
  logic en_small = 1'b0;
  logic en_tall = 1'b0;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  vga_timing_gen_param_if #(.CW(10)) vd ();
  vga_timing_gen_param_if #(.CW(10)) vs ();
  vga_timing_gen_param_if #(.CW(10)) vt ();

  vga_timing_gen_param dut_def (
    .clk    (clk),
    .reset  (reset),
    .enable (en_def),
    .vga_o  (vd)
  );

  vga_timing_gen_param #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .CLK_DIV(1), .CW(10)
  ) dut_small (
    .clk    (clk),
    .reset  (reset),
    .enable (en_small),
    .vga_o  (vs)
  );

  vga_timing_gen_param #(
    .H_ACTIVE(1), .H_FP(1), .H_SYNC(1), .H_BP(1), .CLK_DIV(1), .CW(10)
  ) dut_tall (
    .clk    (clk),
    .reset  (reset),
    .enable (en_tall),
    .vga_o  (vt)
  );

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    en_def = 1'b1; en_small = 1'b1; en_tall = 1'b1;
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (vd.pixel_tick !== 1'b0) begin failures++; $display("FAIL reset_tick: got %0b expected 0", vd.pixel_tick); end
    checks++; if (vd.h_sync !== 1'b1) begin failures++; $display("FAIL reset_hsync: got %0b expected 1", vd.h_sync); end
    checks++; if (vd.v_sync !== 1'b1) begin failures++; $display("FAIL reset_vsync: got %0b expected 1", vd.v_sync); end
    checks++; if (vd.video_on !== 1'b0) begin failures++; $display("FAIL reset_video: got %0b expected 0", vd.video_on); end
    checks++; if (vd.pixel_x !== 10'd0 || vd.pixel_y !== 10'd0) begin failures++; $display("FAIL reset_xy: got %0d,%0d expected 0,0", vd.pixel_x, vd.pixel_y); end
    checks++; if (vd.line_start !== 1'b0 || vd.frame_start !== 1'b0) begin failures++; $display("FAIL reset_pulses: got %0b%0b expected 00", vd.line_start, vd.frame_start); end
    checks++; if (vs.h_sync !== 1'b0 || vs.v_sync !== 1'b0) begin failures++; $display("FAIL reset_small_sync: got %0b%0b expected 00", vs.h_sync, vs.v_sync); end
    checks++; if (vs.pixel_tick !== 1'b0) begin failures++; $display("FAIL reset_small_tick: got %0b expected 0", vs.pixel_tick); end
    reset = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_tick_rate();
    int last;
    int n;
    last = -1; n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (vd.pixel_tick === 1'b1) begin
        if (last >= 0) begin
          checks++;
          if ((cyc - last) !== 4) begin failures++; $display("FAIL tick_spacing: got %0d expected 4", cyc - last); end
        end
        last = cyc;
        n++;
      end
    end
    checks++; if (n !== 10) begin failures++; $display("FAIL tick_count: got %0d expected 10", n); end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_line_period();
    int t0;
    bit got;
    got = 1'b0;
    for (int i = 0; i < 3300 && !got; i++) begin @(negedge clk); if (vd.line_start === 1'b1) got = 1'b1; end
    checks++; if (!got) begin failures++; $display("FAIL line_wait: got timeout expected line_start"); end
    t0 = cyc;
    checks++; if (vd.pixel_x !== 10'd0) begin failures++; $display("FAIL line_x0: got %0d expected 0", vd.pixel_x); end
    @(negedge clk);
    checks++; if (vd.line_start !== 1'b0) begin failures++; $display("FAIL line_width: got %0b expected 0", vd.line_start); end
    got = 1'b0;
    for (int i = 0; i < 3300 && !got; i++) begin @(negedge clk); if (vd.line_start === 1'b1) got = 1'b1; end
    checks++; if (!got || (cyc - t0) !== 3200) begin failures++; $display("FAIL line_period: got %0d expected 3200", cyc - t0); end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_hsync_video();
    bit got;
    int bad_hs, bad_vid, bad_x, lows, vis, first_low, last_low;
    int x;
    got = 1'b0; bad_hs = 0; bad_vid = 0; bad_x = 0; lows = 0; vis = 0; first_low = -1; last_low = -1;
    for (int i = 0; i < 3300 && !got; i++) begin @(negedge clk); if (vd.line_start === 1'b1) got = 1'b1; end
    checks++; if (!got) begin failures++; $display("FAIL hs_wait: got timeout expected line_start"); end
    for (int i = 0; i < 3200; i++) begin
      if (i > 0) @(negedge clk);
      x = int'(vd.pixel_x);
      if (x !== i / 4) bad_x++;
      if (vd.h_sync !== ((x >= 656 && x <= 751) ? 1'b0 : 1'b1)) bad_hs++;
      if (vd.video_on !== ((x < 640) ? 1'b1 : 1'b0)) bad_vid++;
      if (vd.h_sync === 1'b0) begin lows++; if (first_low < 0) first_low = x; last_low = x; end
      if (vd.video_on === 1'b1) vis++;
    end
    checks++; if (bad_x !== 0) begin failures++; $display("FAIL hs_xseq: got %0d bad samples expected 0", bad_x); end
    checks++; if (bad_hs !== 0) begin failures++; $display("FAIL hs_decode: got %0d bad samples expected 0", bad_hs); end
    checks++; if (lows !== 384) begin failures++; $display("FAIL hs_width: got %0d clk expected 384", lows); end
    checks++; if (first_low !== 656 || last_low !== 751) begin failures++; $display("FAIL hs_range: got %0d..%0d expected 656..751", first_low, last_low); end
    checks++; if (bad_vid !== 0 || vis !== 2560) begin failures++; $display("FAIL video_line: got %0d bad, %0d clk expected 0 bad, 2560 clk", bad_vid, vis); end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_small_config();
    bit got;
    int bad_tick, bad_pos, bad_hs, bad_vs, bad_vid, bad_pulse, hs_high;
    int x, y;
    got = 1'b0; bad_tick = 0; bad_pos = 0; bad_hs = 0; bad_vs = 0; bad_vid = 0; bad_pulse = 0; hs_high = 0;
    for (int i = 0; i < 60 && !got; i++) begin @(negedge clk); if (vs.frame_start === 1'b1) got = 1'b1; end
    checks++; if (!got) begin failures++; $display("FAIL small_wait: got timeout expected frame_start"); end
    for (int i = 0; i < 48; i++) begin
      if (i > 0) @(negedge clk);
      x = int'(vs.pixel_x); y = int'(vs.pixel_y);
      if (vs.pixel_tick !== 1'b1) bad_tick++;
      if (x !== i % 8 || y !== i / 8) bad_pos++;
      if (vs.h_sync !== ((x == 5 || x == 6) ? 1'b1 : 1'b0)) bad_hs++;
      if (vs.h_sync === 1'b1) hs_high++;
      if (vs.v_sync !== ((y == 4) ? 1'b1 : 1'b0)) bad_vs++;
      if (vs.video_on !== ((x < 4 && y < 3) ? 1'b1 : 1'b0)) bad_vid++;
      if (vs.frame_start !== ((i == 0) ? 1'b1 : 1'b0) || vs.line_start !== ((i % 8 == 0) ? 1'b1 : 1'b0)) bad_pulse++;
    end
    checks++; if (bad_tick !== 0) begin failures++; $display("FAIL small_tick: got %0d low samples expected 0", bad_tick); end
    checks++; if (bad_pos !== 0) begin failures++; $display("FAIL small_xy: got %0d bad samples expected 0", bad_pos); end
    checks++; if (bad_hs !== 0 || hs_high !== 12) begin failures++; $display("FAIL small_hsync: got %0d bad, %0d high expected 0 bad, 12 high", bad_hs, hs_high); end
    checks++; if (bad_vs !== 0 || bad_vid !== 0) begin failures++; $display("FAIL small_vs_video: got %0d/%0d bad expected 0/0", bad_vs, bad_vid); end
    checks++; if (bad_pulse !== 0) begin failures++; $display("FAIL small_pulses: got %0d bad samples expected 0", bad_pulse); end
    @(negedge clk);
    checks++; if (vs.frame_start !== 1'b1) begin failures++; $display("FAIL small_frame_period: got %0b at 48 clk expected 1", vs.frame_start); end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_vsync_frame();
    bit got;
    int px, py, bad_pos, bad_vs, bad_vid, lows, vis, first_low, last_low;
    int x, y;
    got = 1'b0; px = -1; py = -1; bad_pos = 0; bad_vs = 0; bad_vid = 0; lows = 0; vis = 0; first_low = -1; last_low = -1;
    for (int i = 0; i < 2200 && !got; i++) begin
      @(negedge clk);
      if (vt.frame_start === 1'b1) got = 1'b1;
      else begin px = int'(vt.pixel_x); py = int'(vt.pixel_y); end
    end
    checks++; if (!got) begin failures++; $display("FAIL tall_wait: got timeout expected frame_start"); end
    checks++; if (px !== 3 || py !== 524) begin failures++; $display("FAIL wrap_prev: got %0d,%0d expected 3,524", px, py); end
    checks++; if (vt.line_start !== 1'b1 || vt.pixel_x !== 10'd0 || vt.pixel_y !== 10'd0 || vt.v_sync !== 1'b1) begin
      failures++; $display("FAIL wrap_state: got ls=%0b x=%0d y=%0d vs=%0b expected ls=1 x=0 y=0 vs=1", vt.line_start, vt.pixel_x, vt.pixel_y, vt.v_sync);
    end
    for (int i = 0; i < 2100; i++) begin
      if (i > 0) @(negedge clk);
      x = int'(vt.pixel_x); y = int'(vt.pixel_y);
      if (i == 1 && (vt.frame_start !== 1'b0 || vt.line_start !== 1'b0)) begin
        checks++; failures++; $display("FAIL wrap_width: got fs=%0b ls=%0b expected 0,0", vt.frame_start, vt.line_start);
      end
      if (x !== i % 4 || y !== i / 4) bad_pos++;
      if (vt.v_sync !== ((y >= 490 && y <= 491) ? 1'b0 : 1'b1)) bad_vs++;
      if (vt.v_sync === 1'b0) begin lows++; if (first_low < 0) first_low = y; last_low = y; end
      if (vt.video_on !== ((x < 1 && y < 480) ? 1'b1 : 1'b0)) bad_vid++;
      if (vt.video_on === 1'b1) vis++;
    end
    checks++; if (bad_pos !== 0) begin failures++; $display("FAIL tall_xy: got %0d bad samples expected 0", bad_pos); end
    checks++; if (bad_vs !== 0 || lows !== 8) begin failures++; $display("FAIL vsync_width: got %0d bad, %0d clk expected 0 bad, 8 clk", bad_vs, lows); end
    checks++; if (first_low !== 490 || last_low !== 491) begin failures++; $display("FAIL vsync_range: got %0d..%0d expected 490..491", first_low, last_low); end
    checks++; if (bad_vid !== 0 || vis !== 480) begin failures++; $display("FAIL tall_video: got %0d bad, %0d clk expected 0 bad, 480 clk", bad_vid, vis); end
    @(negedge clk);
    checks++; if (vt.frame_start !== 1'b1) begin failures++; $display("FAIL frame_period: got %0b at 2100 clk expected 1", vt.frame_start); end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_enable_freeze();
    bit got;
    int ycap, bad_hold, ticks, pulses;
    logic hs0, vs0, vid0;
    got = 1'b0; bad_hold = 0; ticks = 0; pulses = 0;
    for (int i = 0; i < 3300 && !got; i++) begin @(negedge clk); if (vd.pixel_x === 10'd639) got = 1'b1; end
    checks++; if (!got) begin failures++; $display("FAIL freeze_wait: got timeout expected x=639"); end
    ycap = int'(vd.pixel_y); hs0 = vd.h_sync; vs0 = vd.v_sync; vid0 = vd.video_on;
    en_def = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (vd.pixel_tick !== 1'b0) ticks++;
      if (vd.line_start !== 1'b0 || vd.frame_start !== 1'b0) pulses++;
      if (vd.pixel_x !== 10'd639 || int'(vd.pixel_y) !== ycap || vd.h_sync !== hs0 || vd.v_sync !== vs0 || vd.video_on !== vid0) bad_hold++;
    end
    checks++; if (ticks !== 0) begin failures++; $display("FAIL freeze_tick: got %0d ticks expected 0", ticks); end
    checks++; if (bad_hold !== 0 || pulses !== 0) begin failures++; $display("FAIL freeze_hold: got %0d changed, %0d pulses expected 0,0", bad_hold, pulses); end
    checks++; if (vid0 !== 1'b1 || hs0 !== 1'b1) begin failures++; $display("FAIL freeze_x639: got vid=%0b hs=%0b expected 1,1", vid0, hs0); end
    en_def = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin @(negedge clk); if (vd.pixel_x !== 10'd639) got = 1'b1; end
    checks++; if (!got || vd.pixel_x !== 10'd640 || int'(vd.pixel_y) !== ycap) begin
      failures++; $display("FAIL resume_pos: got %0d,%0d expected 640,%0d", vd.pixel_x, vd.pixel_y, ycap);
    end
    checks++; if (vd.video_on !== 1'b0 || vd.h_sync !== 1'b1) begin failures++; $display("FAIL resume_decode: got vid=%0b hs=%0b expected 0,1", vd.video_on, vd.h_sync); end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset_midframe();
    bit got;
    int ticks, frames;
    got = 1'b0; ticks = 0; frames = 0;
    for (int i = 0; i < 3300 && !got; i++) begin @(negedge clk); if (vd.pixel_x === 10'd300) got = 1'b1; end
    checks++; if (!got) begin failures++; $display("FAIL mid_wait: got timeout expected x=300"); end
    reset = 1'b0;
    #1;
    checks++; if (vd.pixel_x !== 10'd0 || vd.pixel_y !== 10'd0 || vd.video_on !== 1'b0 || vd.pixel_tick !== 1'b0) begin
      failures++; $display("FAIL mid_reset_xy: got x=%0d y=%0d vid=%0b tick=%0b expected 0,0,0,0", vd.pixel_x, vd.pixel_y, vd.video_on, vd.pixel_tick);
    end
    checks++; if (vd.h_sync !== 1'b1 || vd.v_sync !== 1'b1 || vd.line_start !== 1'b0 || vd.frame_start !== 1'b0) begin
      failures++; $display("FAIL mid_reset_sync: got hs=%0b vs=%0b ls=%0b fs=%0b expected 1,1,0,0", vd.h_sync, vd.v_sync, vd.line_start, vd.frame_start);
    end
    @(negedge clk);
    reset = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 3400 && !got; i++) begin
      @(negedge clk);
      if (vd.frame_start === 1'b1) frames++;
      if (vd.line_start === 1'b1) got = 1'b1;
      else if (vd.pixel_tick === 1'b1) ticks++;
    end
    checks++; if (!got || ticks !== 800) begin failures++; $display("FAIL mid_first_line: got %0d ticks expected 800", ticks); end
    checks++; if (frames !== 0) begin failures++; $display("FAIL mid_no_frame: got %0d frame_start expected 0", frames); end
    checks++; if (vd.pixel_x !== 10'd0 || vd.pixel_y !== 10'd1) begin failures++; $display("FAIL mid_line_pos: got %0d,%0d expected 0,1", vd.pixel_x, vd.pixel_y); end
  endtask

  // ---------------------------------------------------------------------------
  initial begin
    test_reset();
    test_tick_rate();
    test_line_period();
    test_hsync_video();
    test_small_config();
    test_vsync_frame();
    test_enable_freeze();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_vga_timing_gen_param
`default_nettype wire
